// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop PWM controller: owns the period counter and steps the live
// duty one count toward the accepted target every STEP_PERIODS PWM periods.
module pwm_ramp_ctrl #(
  parameter int PERIOD       = 10,
  parameter int DUTY_W       = 4,
  parameter int STEP_PERIODS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tgt_valid,
  input  logic [DUTY_W-1:0] tgt_duty,
  output logic              tgt_ready,
  output logic [DUTY_W-1:0] duty,
  output logic              pwm_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} state_t;

  localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [DUTY_W-1:0] PERIOD_V  = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] LAST_CNT  = DUTY_W'(PERIOD - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEP_PERIODS - 1);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              done_q, done_d;

  logic              period_end;
  logic              step_tick;
  logic              xfer;
  logic [DUTY_W-1:0] req_duty;

  assign period_end = (state_q != IDLE) && (cnt_q == LAST_CNT);
  assign step_tick  = period_end && (step_q == LAST_STEP);
  assign xfer       = tgt_valid && tgt_ready;
  assign req_duty   = (tgt_duty > PERIOD_V) ? PERIOD_V : tgt_duty;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values computed by the combinational processes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      duty_q   <= '0;
      target_q <= '0;
      step_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    done_d   = 1'b0;
    target_d = xfer ? req_duty : target_q;

    unique case (state_q)
      IDLE: begin
        duty_d = '0;
        if (en) begin
          if (target_d != '0) begin
            state_d = RAMP;
          end else begin
            state_d = HOLD;
            done_d  = 1'b1;
          end
        end
      end
      RAMP: begin
        // Dropping en wins over a step landing on the same edge.
        if (!en) begin
          state_d = STOP;
        end else if (step_tick) begin
          duty_d = (target_q > duty_q) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);
          if (duty_d == target_q) begin
            state_d = HOLD;
            done_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!en) begin
          state_d = STOP;
        end else if (xfer) begin
          if (req_duty != duty_q) state_d = RAMP;
          else                    done_d  = 1'b1;
        end
      end
      STOP: begin
        if (duty_q == '0)   state_d = IDLE;
        else if (step_tick) duty_d  = duty_q - DUTY_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || state_d == IDLE) cnt_d = '0;
    else if (period_end)                    cnt_d = '0;
    else                                    cnt_d = cnt_q + DUTY_W'(1);

    // The step timer restarts whenever a ramp or stop begins, even mid-period.
    if ((state_d == RAMP || state_d == STOP) && state_d != state_q) step_d = '0;
    else if (step_tick)                                             step_d = '0;
    else if (period_end)                                            step_d = step_q + STEP_W'(1);
    else                                                            step_d = step_q;
  end

  always_comb begin
    tgt_ready = (state_q == IDLE) || (state_q == HOLD);
    busy      = (state_q == RAMP) || (state_q == STOP);
    pwm_out   = (state_q != IDLE) && (cnt_q < duty_q);
    duty      = duty_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios with fixed expectations plus a
// per-cycle scoreboard against a cycle-countdown reference model.
module tb_pwm_ramp_ctrl;

  localparam int P = 10;
  localparam int S = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         tgt_valid;
  logic [W-1:0] tgt_duty;
  logic         tgt_ready;
  logic [W-1:0] duty;
  logic         pwm_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  pwm_ramp_ctrl #(.PERIOD(P), .DUTY_W(W), .STEP_PERIODS(S)) dut (
    .clk(clk), .rst(rst), .en(en), .tgt_valid(tgt_valid), .tgt_duty(tgt_duty),
    .tgt_ready(tgt_ready), .duty(duty), .pwm_out(pwm_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: modes follow the behavioural description; the step timer is
  // a countdown of clock cycles to the next step edge.
  localparam int M_OFF = 0, M_UP = 1, M_HOLD = 2, M_DOWN = 3;
  int m_mode = M_OFF, m_duty = 0, m_tgt = 0, m_pos = 0, m_left = 0;
  bit m_done = 1'b0;

  task automatic model_reset();
    m_mode = M_OFF; m_duty = 0; m_tgt = 0; m_pos = 0; m_left = 0; m_done = 1'b0;
  endtask

  task automatic model_step();
    int nmode, nduty, npos, nt;
    bit acc, pe, tick, ndone;
    acc   = tgt_valid && (m_mode == M_OFF || m_mode == M_HOLD);
    nt    = (int'(tgt_duty) > P) ? P : int'(tgt_duty);
    pe    = (m_mode != M_OFF) && (m_pos == P - 1);
    tick  = (m_mode == M_UP || m_mode == M_DOWN) && (m_left == 1);
    nmode = m_mode; nduty = m_duty; ndone = 1'b0;
    case (m_mode)
      M_OFF: if (en) begin
        if ((acc ? nt : m_tgt) != 0) nmode = M_UP;
        else begin nmode = M_HOLD; ndone = 1'b1; end
      end
      M_UP: if (!en) nmode = M_DOWN;
        else if (tick) begin
          nduty = m_duty + ((m_tgt > m_duty) ? 1 : -1);
          if (nduty == m_tgt) begin nmode = M_HOLD; ndone = 1'b1; end
        end
      M_HOLD: if (!en) nmode = M_DOWN;
        else if (acc) begin
          if (nt != m_duty) nmode = M_UP; else ndone = 1'b1;
        end
      default: if (m_duty == 0) nmode = M_OFF; else if (tick) nduty = m_duty - 1;
    endcase
    npos = (m_mode == M_OFF || nmode == M_OFF) ? 0 : (pe ? 0 : m_pos + 1);
    if ((nmode == M_UP || nmode == M_DOWN) && nmode != m_mode) m_left = S * P - npos;
    else if (m_mode == M_UP || m_mode == M_DOWN) m_left = tick ? S * P : m_left - 1;
    if (acc) m_tgt = nt;
    m_mode = nmode; m_duty = nduty; m_pos = npos; m_done = ndone;
  endtask

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (!rst) begin
      model_step();
      #1;
      if (!rst) begin
        checks += 5;
        if (duty !== W'(m_duty)) begin
          errors++; $display("FAIL sb_duty t=%0t got %0d exp %0d", $time, duty, m_duty);
        end
        if (pwm_out !== (m_mode != M_OFF && m_pos < m_duty)) begin
          errors++; $display("FAIL sb_pwm t=%0t got %0b exp %0b", $time, pwm_out, (m_mode != M_OFF && m_pos < m_duty));
        end
        if (busy !== (m_mode == M_UP || m_mode == M_DOWN)) begin
          errors++; $display("FAIL sb_busy t=%0t got %0b mode %0d", $time, busy, m_mode);
        end
        if (tgt_ready !== (m_mode == M_OFF || m_mode == M_HOLD)) begin
          errors++; $display("FAIL sb_ready t=%0t got %0b mode %0d", $time, tgt_ready, m_mode);
        end
        if (done !== m_done) begin
          errors++; $display("FAIL sb_done t=%0t got %0b exp %0b", $time, done, m_done);
        end
      end
    end
  end

  // Advance n clock edges and land 2 time units after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_duty(input int v, input int bound, output int took);
    took = 0;
    while (duty !== W'(v) && took <= bound) begin
      cyc(1);
      took++;
    end
    if (took > bound) begin
      checks++; errors++;
      $display("FAIL wait_duty_%0d got %0d after %0d cycles", v, duty, took);
    end
  endtask

  task automatic send(input int d);
    tgt_valid = 1'b1; tgt_duty = W'(d);
    cyc(1);
    tgt_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; tgt_valid = 1'b0; tgt_duty = '0;
    #3;
    checks++;
    if ({duty, pwm_out, busy, done, tgt_ready} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_outputs got duty=%0d pwm=%0b busy=%0b done=%0b rdy=%0b exp 0 0 0 0 1",
                         duty, pwm_out, busy, done, tgt_ready);
    end
    cyc(3);
    rst = 1'b0;
    cyc(2);
    checks++;
    if (busy !== 1'b0 || duty !== 4'd0) begin
      errors++; $display("FAIL reset_idle got busy=%0b duty=%0d exp 0 0", busy, duty);
    end
  endtask

  task automatic test_ramp_up();
    int highs;
    send(5);
    en = 1'b1;
    cyc(1);
    checks++;
    if (busy !== 1'b1 || tgt_ready !== 1'b0) begin
      errors++; $display("FAIL ramp_up_entry got busy=%0b rdy=%0b exp 1 0", busy, tgt_ready);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc(S * P - 1);
      checks++;
      if (duty !== W'(i - 1)) begin
        errors++; $display("FAIL ramp_up_before_%0d got %0d exp %0d", i, duty, i - 1);
      end
      cyc(1);
      checks++;
      if (duty !== W'(i) || done !== (i == 5)) begin
        errors++; $display("FAIL ramp_up_step_%0d got duty=%0d done=%0b exp %0d %0b", i, duty, done, i, i == 5);
      end
    end
    cyc(1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ramp_up_hold got done=%0b busy=%0b exp 0 0", done, busy);
    end
    highs = 0;
    for (int i = 0; i < P; i++) begin
      highs += int'(pwm_out);
      cyc(1);
    end
    checks++;
    if (highs != 5) begin
      errors++; $display("FAIL ramp_up_pwm_high got %0d exp 5", highs);
    end
  endtask

  task automatic test_ramp_down();
    int took;
    checks++;
    if (tgt_ready !== 1'b1) begin
      errors++; $display("FAIL down_ready_before got %0b exp 1", tgt_ready);
    end
    send(2);
    checks++;
    if (busy !== 1'b1 || tgt_ready !== 1'b0) begin
      errors++; $display("FAIL down_entry got busy=%0b rdy=%0b exp 1 0", busy, tgt_ready);
    end
    wait_duty(4, S * P + 5, took);
    for (int v = 3; v >= 2; v--) begin
      wait_duty(v, S * P + 5, took);
      checks++;
      if (took != S * P) begin
        errors++; $display("FAIL down_spacing_%0d got %0d exp %0d", v, took, S * P);
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL down_done got %0b exp 1", done);
    end
    cyc(1);
    checks++;
    if (tgt_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL down_hold got rdy=%0b busy=%0b done=%0b exp 1 0 0", tgt_ready, busy, done);
    end
  endtask

  task automatic test_clamp();
    int took, lows;
    send(15);
    wait_duty(10, 8 * S * P + 10, took);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL clamp_done got %0b exp 1", done);
    end
    lows = 0;
    for (int i = 0; i < 2 * P; i++) begin
      lows += int'(!pwm_out);
      cyc(1);
    end
    checks++;
    if (lows != 0) begin
      errors++; $display("FAIL clamp_pwm_const got %0d low cycles exp 0", lows);
    end
    send(10);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || duty !== 4'd10) begin
      errors++; $display("FAIL same_target got busy=%0b done=%0b duty=%0d exp 0 1 10", busy, done, duty);
    end
    cyc(1);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL same_target_pulse got %0b exp 0", done);
    end
  endtask

  task automatic test_stop();
    int took;
    send(3);
    wait_duty(3, 7 * S * P + 10, took);
    en = 1'b0;
    cyc(1);
    checks++;
    if (busy !== 1'b1 || tgt_ready !== 1'b0) begin
      errors++; $display("FAIL stop_entry got busy=%0b rdy=%0b exp 1 0", busy, tgt_ready);
    end
    wait_duty(2, S * P + 5, took);
    en = 1'b1;
    for (int v = 1; v >= 0; v--) begin
      wait_duty(v, S * P + 5, took);
      checks++;
      if (took != S * P) begin
        errors++; $display("FAIL stop_spacing_%0d got %0d exp %0d", v, took, S * P);
      end
    end
    cyc(1);
    checks++;
    if (busy !== 1'b0 || pwm_out !== 1'b0 || tgt_ready !== 1'b1) begin
      errors++; $display("FAIL stop_idle got busy=%0b pwm=%0b rdy=%0b exp 0 0 1", busy, pwm_out, tgt_ready);
    end
    cyc(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL restart got busy=%0b exp 1", busy);
    end
    wait_duty(1, S * P + 5, took);
    checks++;
    if (took != S * P) begin
      errors++; $display("FAIL restart_first_step got %0d exp %0d", took, S * P);
    end
  endtask

  task automatic test_reset_mid();
    int took;
    wait_duty(3, 3 * S * P, took);
    cyc(1);
    send(6);
    wait_duty(4, S * P + 5, took);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (duty !== 4'd0 || pwm_out !== 1'b0 || busy !== 1'b0 || tgt_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset got duty=%0d pwm=%0b busy=%0b rdy=%0b done=%0b exp 0 0 0 1 0",
                         duty, pwm_out, busy, tgt_ready, done);
    end
    tgt_valid = 1'b1; tgt_duty = 4'd7;
    cyc(2);
    tgt_valid = 1'b0;
    rst = 1'b0;
    cyc(1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || duty !== 4'd0) begin
      errors++; $display("FAIL post_reset_target got busy=%0b done=%0b duty=%0d exp 0 1 0", busy, done, duty);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) en = ~en;
      tgt_valid = ($urandom_range(0, 29) == 0);
      tgt_duty  = W'($urandom_range(0, 15));
      cyc(1);
    end
    tgt_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_clamp();
    test_stop();
    test_reset_mid();
    test_random();
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
